// File: rtl/arbiter_types_pkg.sv
// Shared types for the icache/dcache memory-port arbiter.
// Holds the FSM state encoding, the requester identity and the default widths.
package arbiter_types;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin selector.
// A lone requester always wins; a tie goes to the side that was not granted last.
module arb_rr_pick
  import arbiter_types::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = i_req | d_req;
    winner = REQ_D;
    if (i_req && d_req) begin
      winner = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (i_req) begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the cacheline adaptor between icache and dcache, one whole line
// transaction at a time, with round-robin tie breaking and per-side grant counters.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              ca_read,
  output logic              ca_write,
  output logic [ADDR_W-1:0] ca_addr,
  output logic [LINE_W-1:0] ca_wdata,
  input  logic [LINE_W-1:0] ca_rdata,
  input  logic              ca_resp,
  output logic [CNT_W-1:0]  i_grant_count,
  output logic [CNT_W-1:0]  d_grant_count
);

  arb_state_t        state, state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              i_req, d_req;
  logic              pick_valid, pick_winner;
  logic              grant_i, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  arb_rr_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign grant_i = (state == IDLE) && pick_valid && (pick_winner == REQ_I);
  assign grant_d = (state == IDLE) && pick_valid && (pick_winner == REQ_D);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_i) state_next = SERVE_I;
               else if (grant_d) state_next = SERVE_D;
      SERVE_I: if (ca_resp) state_next = RELEASE;
      SERVE_D: if (ca_resp) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operation is captured on the granting edge so the downstream view stays
  // stable even if the requester changes its inputs mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      last_grant    <= REQ_D;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else if (grant_i) begin
      addr_q        <= i_pmem_addr;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      last_grant    <= REQ_I;
      i_grant_count <= i_grant_count + CNT_W'(1);
    end else if (grant_d) begin
      addr_q        <= d_pmem_addr;
      wdata_q       <= d_pmem_write ? d_pmem_wdata : '0;
      write_q       <= d_pmem_write;
      last_grant    <= REQ_D;
      d_grant_count <= d_grant_count + CNT_W'(1);
    end
  end

  always_comb begin
    ca_read      = 1'b0;
    ca_write     = 1'b0;
    ca_addr      = '0;
    ca_wdata     = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    case (state)
      SERVE_I: begin
        ca_read = 1'b1;
        ca_addr = addr_q;
        if (ca_resp) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = ca_rdata;
        end
      end
      SERVE_D: begin
        ca_read  = ~write_q;
        ca_write = write_q;
        ca_addr  = addr_q;
        ca_wdata = wdata_q;
        if (ca_resp) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = ca_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
